// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

    // Width of the shared cycle counter: it only ever needs to reach the
    // largest terminal value (max - 1), so clog2(max) is enough.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Width of the retry counter, which must be able to hold MAX_RETRIES.
    function automatic int retry_width(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous active-high reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous input into the i_clk domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / recovery sequencer running on the PLL reference clock.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  HOLD       | PLL held in reset for RST_HOLD_CYCLES
//  WAIT_LOCK  | PLL released, waiting for synced lock (with timeout)
//  STABLE     | lock seen, must stay high LOCK_STABLE_CYCLES in a row
//  RELEASE    | lock stable, downstream reset held POST_LOCK_RST_CYCLES
//  RUN        | downstream out of reset, watching for lock loss
//  FAULT      | retries exhausted, PLL held in reset until sw/rst
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES      = 10,
    parameter int LOCK_TIMEOUT_CYCLES  = 50000,
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int POST_LOCK_RST_CYCLES = 16,
    parameter int MAX_RETRIES          = 3,
    parameter int LOSS_CNT_W           = 8,
    localparam int RETRY_W             = retry_width(MAX_RETRIES)
) (
    input  logic                  i_refclk,
    input  logic                  i_rst,
    input  logic                  i_pll_locked,
    input  logic                  i_sw_reset_req,
    output logic                  o_pll_rst,
    output logic                  o_sys_rst,
    output logic                  o_sys_ready,
    output logic                  o_fault,
    output logic [RETRY_W-1:0]    o_retry_cnt,
    output logic [LOSS_CNT_W-1:0] o_lock_loss_cnt,
    output logic [STATE_W-1:0]    o_seq_state
);

    localparam int CNT_W = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                     LOCK_STABLE_CYCLES, POST_LOCK_RST_CYCLES);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   POST_LAST    = CNT_W'(POST_LOCK_RST_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    seq_state_t              r_state;
    seq_state_t              w_next_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [RETRY_W-1:0]      r_retry_cnt;
    logic [RETRY_W-1:0]      w_retry_next;
    logic [LOSS_CNT_W-1:0]   r_loss_cnt;
    logic                    w_locked_s;
    logic                    w_cnt_clr;
    logic                    w_retry_inc;
    logic                    w_retry_clr;
    logic                    w_loss_inc;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_locked_s)
    );

    assign w_retry_next = r_retry_cnt + RETRY_W'(1);

    // State register.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the strobes that drive the counters.
    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_retry_inc  = 1'b0;
        w_retry_clr  = 1'b0;
        w_loss_inc   = 1'b0;

        if (i_sw_reset_req) begin
            // Software restart always begins a fresh hold period.
            w_next_state = ST_HOLD;
            w_cnt_clr    = 1'b1;
            w_retry_clr  = 1'b1;
        end else begin
            unique case (r_state)
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_next_state = ST_WAIT_LOCK;
                        w_cnt_clr    = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock takes precedence over a coincident timeout.
                    if (w_locked_s) begin
                        w_next_state = ST_STABLE;
                        w_cnt_clr    = 1'b1;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_retry_inc  = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_next_state = (w_retry_next == RETRY_LIMIT) ? ST_FAULT : ST_HOLD;
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        w_next_state = ST_WAIT_LOCK;
                        w_cnt_clr    = 1'b1;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_next_state = ST_RELEASE;
                        w_cnt_clr    = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!w_locked_s) begin
                        w_next_state = ST_WAIT_LOCK;
                        w_cnt_clr    = 1'b1;
                    end else if (r_cnt == POST_LAST) begin
                        w_next_state = ST_RUN;
                        w_cnt_clr    = 1'b1;
                        w_retry_clr  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        w_next_state = ST_HOLD;
                        w_cnt_clr    = 1'b1;
                        w_loss_inc   = 1'b1;
                    end
                end
                ST_FAULT: begin
                    w_next_state = ST_FAULT;
                end
                default: begin
                    w_next_state = ST_HOLD;
                    w_cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    // Shared cycle counter; idle in RUN and FAULT where nothing is timed.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if ((r_state != ST_RUN) && (r_state != ST_FAULT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Failed-attempt counter for the current sequence.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_retry_cnt <= '0;
        end else if (w_retry_clr) begin
            r_retry_cnt <= '0;
        end else if (w_retry_inc) begin
            r_retry_cnt <= w_retry_next;
        end
    end

    // Saturating count of lock losses seen while running.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_loss_cnt <= '0;
        end else if (w_loss_inc && (r_loss_cnt != {LOSS_CNT_W{1'b1}})) begin
            r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
        end
    end

    assign o_pll_rst       = (r_state == ST_HOLD) || (r_state == ST_FAULT);
    assign o_sys_rst       = (r_state != ST_RUN);
    assign o_sys_ready     = (r_state == ST_RUN);
    assign o_fault         = (r_state == ST_FAULT);
    assign o_retry_cnt     = r_retry_cnt;
    assign o_lock_loss_cnt = r_loss_cnt;
    assign o_seq_state     = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

    localparam int MAX_RETRIES = 2;
    localparam int RETRY_W     = 2;
    localparam int LOSS_W      = 8;

    localparam logic [2:0] S_HOLD    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_STABLE  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    logic               refclk = 1'b0;
    logic               rst = 1'b1;
    logic               pll_locked = 1'b0;
    logic               sw_reset_req = 1'b0;
    logic               pll_rst;
    logic               sys_rst;
    logic               sys_ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;
    logic [LOSS_W-1:0]  lock_loss_cnt;
    logic [2:0]         seq_state;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES  (20),
        .LOCK_STABLE_CYCLES   (8),
        .POST_LOCK_RST_CYCLES (3),
        .MAX_RETRIES          (MAX_RETRIES),
        .LOSS_CNT_W           (LOSS_W)
    ) dut (
        .i_refclk        (refclk),
        .i_rst           (rst),
        .i_pll_locked    (pll_locked),
        .i_sw_reset_req  (sw_reset_req),
        .o_pll_rst       (pll_rst),
        .o_sys_rst       (sys_rst),
        .o_sys_ready     (sys_ready),
        .o_fault         (fault),
        .o_retry_cnt     (retry_cnt),
        .o_lock_loss_cnt (lock_loss_cnt),
        .o_seq_state     (seq_state)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n;
        n = 0;
        while (seq_state !== st && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(seq_state), 32'(st));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick(2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},   32'(seq_state),     32'(S_HOLD));
        check({tag, "_pll_rst"}, 32'(pll_rst),       32'd1);
        check({tag, "_sys_rst"}, 32'(sys_rst),       32'd1);
        check({tag, "_ready"},   32'(sys_ready),     32'd0);
        check({tag, "_fault"},   32'(fault),         32'd0);
        check({tag, "_retry"},   32'(retry_cnt),     32'd0);
        check({tag, "_loss"},    32'(lock_loss_cnt), 32'd0);
    endtask

    logic exp_pll_rst;

    initial begin
        // ---- 1. reset values and normal bring-up ----
        pll_locked = 1'b0;
        apply_reset();
        check_reset_values("rst");
        rst = 1'b0;
        tick(3);
        check("bring_hold_pll_rst", 32'(pll_rst), 32'd1);
        tick(1);
        check("bring_pll_rst_fall", 32'(pll_rst), 32'd0);
        check("bring_wait_state", 32'(seq_state), 32'(S_WAIT));
        tick(5);
        pll_locked = 1'b1;
        // Next edge is the first to sample lock; release lands 13 edges later.
        tick(13);
        check("bring_sys_rst_hold", 32'(sys_rst), 32'd1);
        tick(1);
        check("bring_sys_rst_rel", 32'(sys_rst), 32'd0);
        check("bring_ready", 32'(sys_ready), 32'd1);
        check("bring_retry", 32'(retry_cnt), 32'd0);

        // ---- one timeout then lock: retry counted, then cleared in RUN ----
        pll_locked = 1'b0;
        apply_reset();
        rst = 1'b0;
        tick(24);
        check("retry_after_timeout", 32'(retry_cnt), 32'd1);
        check("retry_back_in_hold", 32'(seq_state), 32'(S_HOLD));
        pll_locked = 1'b1;
        wait_state(S_RUN, 40, "retry_reach_run");
        check("retry_cleared_run", 32'(retry_cnt), 32'd0);

        // ---- 2. no lock: two attempts then FAULT at edge 48 ----
        pll_locked = 1'b0;
        apply_reset();
        rst = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            tick(1);
            if (k < 4)       exp_pll_rst = 1'b1;
            else if (k < 24) exp_pll_rst = 1'b0;
            else if (k < 28) exp_pll_rst = 1'b1;
            else if (k < 48) exp_pll_rst = 1'b0;
            else             exp_pll_rst = 1'b1;
            check($sformatf("nolock_pll_rst_e%0d", k), 32'(pll_rst), 32'(exp_pll_rst));
            if (k == 47) check("nolock_not_fault_e47", 32'(fault), 32'd0);
        end
        check("nolock_fault", 32'(fault), 32'd1);
        check("nolock_state", 32'(seq_state), 32'(S_FAULT));
        check("nolock_sys_rst", 32'(sys_rst), 32'd1);
        check("nolock_retry", 32'(retry_cnt), 32'(MAX_RETRIES));
        pll_locked = 1'b1;
        tick(10);
        check("fault_terminal", 32'(seq_state), 32'(S_FAULT));

        // ---- 5a. sw_reset_req leaves FAULT ----
        pll_locked = 1'b0;
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        check("swr_fault_state", 32'(seq_state), 32'(S_HOLD));
        check("swr_fault_fault", 32'(fault), 32'd0);
        check("swr_fault_retry", 32'(retry_cnt), 32'd0);
        check("swr_fault_pll_rst", 32'(pll_rst), 32'd1);

        // ---- 3. lock glitch in STABLE ----
        wait_state(S_WAIT, 10, "glitch_reach_wait");
        pll_locked = 1'b1;
        wait_state(S_STABLE, 5, "glitch_reach_stable");
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        check("glitch_still_stable", 32'(seq_state), 32'(S_STABLE));
        tick(1);
        check("glitch_back_wait", 32'(seq_state), 32'(S_WAIT));
        check("glitch_sys_rst", 32'(sys_rst), 32'd1);
        check("glitch_retry", 32'(retry_cnt), 32'd0);
        // Relock was first sampled one edge after the drop edge.
        tick(11);
        check("glitch_sys_rst_hold", 32'(sys_rst), 32'd1);
        tick(1);
        check("glitch_release", 32'(sys_rst), 32'd0);
        check("glitch_run", 32'(seq_state), 32'(S_RUN));

        // ---- 4. lock loss in RUN ----
        pll_locked = 1'b0;
        tick(2);
        check("loss_sys_rst_early", 32'(sys_rst), 32'd0);
        tick(1);
        check("loss_sys_rst", 32'(sys_rst), 32'd1);
        check("loss_ready", 32'(sys_ready), 32'd0);
        check("loss_state", 32'(seq_state), 32'(S_HOLD));
        check("loss_cnt1", 32'(lock_loss_cnt), 32'd1);
        tick(3);
        check("loss_pll_rst_hold", 32'(pll_rst), 32'd1);
        tick(1);
        check("loss_pll_rst_fall", 32'(pll_rst), 32'd0);
        pll_locked = 1'b1;
        tick(13);
        check("loss_reseq_hold", 32'(sys_rst), 32'd1);
        tick(1);
        check("loss_reseq_rel", 32'(sys_rst), 32'd0);

        // ---- 5b. sw_reset_req in RUN does not count as a loss ----
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        check("swr_run_state", 32'(seq_state), 32'(S_HOLD));
        check("swr_run_sys_rst", 32'(sys_rst), 32'd1);
        check("swr_run_loss", 32'(lock_loss_cnt), 32'd1);
        wait_state(S_RUN, 40, "swr_run_relock");

        // ---- 4b. repeated losses saturate the counter ----
        for (int i = 2; i <= 300; i++) begin
            pll_locked = 1'b0;
            tick(3);
            pll_locked = 1'b1;
            if (i == 254) check("sat_cnt254", 32'(lock_loss_cnt), 32'd254);
            if (i == 255) check("sat_cnt255", 32'(lock_loss_cnt), 32'd255);
            if (i == 300) check("sat_cnt300", 32'(lock_loss_cnt), 32'd255);
            wait_state(S_RUN, 40, "sat_relock");
        end

        // ---- 6. rst while in STABLE ----
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        wait_state(S_STABLE, 20, "midrst_reach_stable");
        rst = 1'b1;
        tick(1);
        check_reset_values("midrst");
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
